// File: rtl/add_window_accum_pkg.sv
// Shared types and helpers for the windowed operand-pair accumulator.
package add_window_accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int OP_W  = 4;
  localparam int SUM_W = OP_W + 1;

  // Unsigned add that clamps at 2^w-1 instead of wrapping (w <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input int          w);
    logic [32:0] s;
    logic [32:0] lim;
    s   = {1'b0, x} + {1'b0, y};
    lim = (33'd1 << w) - 33'd1;
    return (s > lim) ? lim[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/add_window_accum.sv
// Registers per-pair sums a+b and totals WIN of them into one saturated
// window result, presented on a valid/ready port with backpressure.
module add_window_accum #(
  parameter int OP_W  = 4,
  parameter int WIN   = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic [OP_W:0]    y,
  output logic             y_valid,
  output logic [3:0]       win_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);
  import add_window_accum_pkg::*;

  localparam int         AW   = ACC_W + 1;
  localparam logic [3:0] LAST = 4'(WIN - 1);

  state_t          state;
  state_t          state_nx;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   acc_sum;
  logic [OP_W:0]   y_new;
  logic            accept;
  logic            closing;

  // The extra accumulator bit doubles as the overflow flag for the output.
  function automatic logic [ACC_W-1:0] clip_out(input logic [AW-1:0] v);
    return v[AW-1] ? {ACC_W{1'b1}} : v[ACC_W-1:0];
  endfunction

  assign y_new   = {1'b0, a} + {1'b0, b};
  assign accept  = in_valid && (state == ACCUM) && !clear;
  assign closing = accept && (win_cnt == LAST);
  assign acc_sum = AW'(sat_add(32'(acc), 32'(y_new), AW));

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (closing) state_nx = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (clear || out_ready) state_nx = ACCUM;
      end
      default: state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ACCUM;
      y       <= '0;
      y_valid <= 1'b0;
      win_cnt <= '0;
      out_sum <= '0;
      out_ovf <= 1'b0;
      acc     <= '0;
    end else begin
      state   <= state_nx;
      y_valid <= accept;
      if (accept) y <= y_new;
      // clear wins over everything; out_sum/out_ovf keep their last values
      if (clear) begin
        acc     <= '0;
        win_cnt <= '0;
      end else if (closing) begin
        out_sum <= clip_out(acc_sum);
        out_ovf <= acc_sum[AW-1];
        acc     <= '0;
        win_cnt <= '0;
      end else if (accept) begin
        acc     <= acc_sum;
        win_cnt <= win_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_add_window_accum.sv
// Directed bench for add_window_accum: three configurations checked every
// cycle against a window-level behavioural model plus literal expectations.
module tb_add_window_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       clear[3];
  logic       in_valid[3];
  logic       out_ready[3];
  logic [3:0] a[3];
  logic [3:0] b[3];
  logic       in_ready[3];
  logic       y_valid[3];
  logic       out_valid[3];
  logic       out_ovf[3];
  logic [4:0] y[3];
  logic [3:0] win_cnt[3];
  logic [7:0] out_sum[3];
  logic [5:0] sum_n6;

  assign out_sum[1] = {2'b00, sum_n6};

  add_window_accum #(.OP_W(4), .WIN(4), .ACC_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .a(a[0]), .b(b[0]), .y(y[0]), .y_valid(y_valid[0]),
    .win_cnt(win_cnt[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_sum(out_sum[0]), .out_ovf(out_ovf[0]));

  add_window_accum #(.OP_W(4), .WIN(4), .ACC_W(6)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .a(a[1]), .b(b[1]), .y(y[1]), .y_valid(y_valid[1]),
    .win_cnt(win_cnt[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_sum(sum_n6), .out_ovf(out_ovf[1]));

  add_window_accum #(.OP_W(4), .WIN(1), .ACC_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .a(a[2]), .b(b[2]), .y(y[2]), .y_valid(y_valid[2]),
    .win_cnt(win_cnt[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_sum(out_sum[2]), .out_ovf(out_ovf[2]));

  localparam int WINS[3] = '{4, 4, 1};
  localparam int MAXS[3] = '{255, 63, 255};

  // Window-level model: running integer total, pending-result flag.
  bit m_hold[3];
  bit m_yv[3];
  bit m_ovf[3];
  int m_y[3];
  int m_cnt[3];
  int m_total[3];
  int m_sum[3];

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < 3; g++) begin
      m_hold[g] = 1'b0; m_yv[g] = 1'b0; m_ovf[g] = 1'b0;
      m_y[g] = 0; m_cnt[g] = 0; m_total[g] = 0; m_sum[g] = 0;
    end
  endtask

  task automatic model_update();
    bit took;
    int s;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int g = 0; g < 3; g++) begin
      took = in_valid[g] && !m_hold[g] && !clear[g];
      s    = int'(a[g]) + int'(b[g]);
      m_yv[g] = took;
      if (took) m_y[g] = s;
      if (clear[g]) begin
        m_total[g] = 0; m_cnt[g] = 0; m_hold[g] = 1'b0;
      end else if (m_hold[g]) begin
        if (out_ready[g]) m_hold[g] = 1'b0;
      end else if (took) begin
        m_total[g] += s;
        m_cnt[g]++;
        if (m_cnt[g] == WINS[g]) begin
          m_sum[g]   = (m_total[g] > MAXS[g]) ? MAXS[g] : m_total[g];
          m_ovf[g]   = (m_total[g] > MAXS[g]);
          m_total[g] = 0; m_cnt[g] = 0; m_hold[g] = 1'b1;
        end
      end
    end
  endtask

  // One clock: compare every output at the falling edge, then advance the
  // model with the inputs seen at the rising edge.
  task automatic step();
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("cyc%0d_in_ready", g),  int'(in_ready[g]),  int'(!m_hold[g]));
      chk($sformatf("cyc%0d_out_valid", g), int'(out_valid[g]), int'(m_hold[g]));
      chk($sformatf("cyc%0d_y_valid", g),   int'(y_valid[g]),   int'(m_yv[g]));
      chk($sformatf("cyc%0d_y", g),         int'(y[g]),         m_y[g]);
      chk($sformatf("cyc%0d_win_cnt", g),   int'(win_cnt[g]),   m_cnt[g]);
      chk($sformatf("cyc%0d_out_sum", g),   int'(out_sum[g]),   m_sum[g]);
      chk($sformatf("cyc%0d_out_ovf", g),   int'(out_ovf[g]),   int'(m_ovf[g]));
    end
    @(posedge clk);
    model_update();
    #2;
  endtask

  task automatic send(input int g, input int av, input int bv, input int exp_y);
    bit took;
    int tries;
    took  = 1'b0;
    tries = 0;
    in_valid[g] = 1'b1;
    a[g] = 4'(av);
    b[g] = 4'(bv);
    while (!took && tries < 40) begin
      took = in_ready[g];
      step();
      tries++;
    end
    in_valid[g] = 1'b0;
    if (!took) begin
      vectors++;
      errors++;
      $display("FAIL send_timeout cfg%0d: got no accept, want accept within 40 cycles", g);
    end
    chk($sformatf("lit%0d_y_valid", g), int'(y_valid[g]), 1);
    chk($sformatf("lit%0d_y", g), int'(y[g]), exp_y);
  endtask

  task automatic send_t1(input int g);
    send(g, 1, 3, 4);
    send(g, 5, 6, 11);
    send(g, 7, 8, 15);
    send(g, 15, 15, 30);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      clear[g] = 1'b0; in_valid[g] = 1'b0; out_ready[g] = 1'b1;
      a[g] = '0; b[g] = '0;
    end
    model_reset();
    @(posedge clk);
    #2;
    chk("rst_y", int'(y[0]), 0);
    chk("rst_y_valid", int'(y_valid[0]), 0);
    chk("rst_win_cnt", int'(win_cnt[0]), 0);
    chk("rst_out_valid", int'(out_valid[0]), 0);
    chk("rst_out_sum", int'(out_sum[0]), 0);
    chk("rst_in_ready", int'(in_ready[0]), 1);
    step();
    rst_n = 1'b1;
    step();

    // Back-to-back window with the sink always ready
    send_t1(0);
    chk("t1_out_valid", int'(out_valid[0]), 1);
    chk("t1_out_sum", int'(out_sum[0]), 60);
    chk("t1_out_ovf", int'(out_ovf[0]), 0);
    chk("t1_in_ready", int'(in_ready[0]), 0);
    chk("t1_model_sum", m_sum[0], 60);
    step();
    chk("t1_out_valid_drop", int'(out_valid[0]), 0);
    chk("t1_in_ready_back", int'(in_ready[0]), 1);

    // Backpressure: result held six cycles
    out_ready[0] = 1'b0;
    send_t1(0);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_sum", int'(out_sum[0]), 60);
      chk("t2_hold_in_ready", int'(in_ready[0]), 0);
      chk("t2_hold_valid", int'(out_valid[0]), 1);
      step();
    end
    chk("t2_hold_sum6", int'(out_sum[0]), 60);
    out_ready[0] = 1'b1;
    step();
    chk("t2_out_valid_drop", int'(out_valid[0]), 0);
    chk("t2_in_ready_back", int'(in_ready[0]), 1);
    send(0, 1, 1, 2);
    chk("t2_win_cnt1", int'(win_cnt[0]), 1);
    clear[0] = 1'b1;
    step();
    clear[0] = 1'b0;
    chk("t2_clear_win_cnt", int'(win_cnt[0]), 0);

    // Clear coincident with a presented pair drops the pair
    send(0, 2, 2, 4);
    send(0, 3, 3, 6);
    in_valid[0] = 1'b1; a[0] = 4'd9; b[0] = 4'd9; clear[0] = 1'b1;
    step();
    in_valid[0] = 1'b0; clear[0] = 1'b0;
    chk("t4_no_y_valid", int'(y_valid[0]), 0);
    chk("t4_win_cnt", int'(win_cnt[0]), 0);
    chk("t4_y_kept", int'(y[0]), 6);
    for (int i = 0; i < 4; i++) send(0, 1, 1, 2);
    chk("t4_out_sum", int'(out_sum[0]), 8);
    chk("t4_out_valid", int'(out_valid[0]), 1);
    step();

    // Saturation with ACC_W=6
    for (int i = 0; i < 4; i++) send(1, 15, 15, 30);
    chk("t3_sat_sum", int'(out_sum[1]), 63);
    chk("t3_sat_ovf", int'(out_ovf[1]), 1);
    chk("t3_model_ovf", int'(m_ovf[1]), 1);
    step();
    for (int i = 0; i < 4; i++) send(1, 1, 1, 2);
    chk("t3_sum", int'(out_sum[1]), 8);
    chk("t3_ovf", int'(out_ovf[1]), 0);
    step();

    // Asynchronous reset while holding a result
    out_ready[0] = 1'b0;
    send_t1(0);
    chk("t5_pre_sum", int'(out_sum[0]), 60);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_async_sum", int'(out_sum[0]), 0);
    chk("t5_async_valid", int'(out_valid[0]), 0);
    chk("t5_async_y", int'(y[0]), 0);
    chk("t5_async_in_ready", int'(in_ready[0]), 1);
    step();
    rst_n = 1'b1;
    out_ready[0] = 1'b1;
    step();
    for (int i = 0; i < 4; i++) send(0, 1, 2, 3);
    chk("t5_out_sum", int'(out_sum[0]), 12);
    step();

    // WIN=1: every pair closes a window
    chk("t6_in_ready0", int'(in_ready[2]), 1);
    send(2, 4, 5, 9);
    chk("t6_sum9", int'(out_sum[2]), 9);
    chk("t6_valid_a", int'(out_valid[2]), 1);
    chk("t6_in_ready1", int'(in_ready[2]), 0);
    step();
    chk("t6_in_ready2", int'(in_ready[2]), 1);
    send(2, 0, 0, 0);
    chk("t6_sum0", int'(out_sum[2]), 0);
    chk("t6_valid_b", int'(out_valid[2]), 1);
    chk("t6_in_ready3", int'(in_ready[2]), 0);
    step();

    // Clear in HOLD discards the result but keeps out_sum
    out_ready[2] = 1'b0;
    send(2, 7, 7, 14);
    chk("t7_valid", int'(out_valid[2]), 1);
    clear[2] = 1'b1;
    step();
    clear[2] = 1'b0;
    chk("t7_valid_drop", int'(out_valid[2]), 0);
    chk("t7_sum_kept", int'(out_sum[2]), 14);
    chk("t7_in_ready", int'(in_ready[2]), 1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
